// File: rtl/hyper_read_packer.sv
// ---------------------------------------------------------------------------
// hyper_read_packer
//
// Packs 16-bit halfwords popped from the HyperBus read CDC FIFO into 32-bit
// read-response beats in the clk0 domain. Handles a halfword-misaligned start
// (the first halfword lands in [31:16] and [15:0] of that beat is zero) and
// drives the last-beat flag. If the FIFO starves for TIMEOUT_CYCLES cycles,
// the rest of the burst is completed with zero-data error beats so the bus
// never hangs.
//
// Ports
//   clk0            system clock
//   rst_i           synchronous active-high reset
//   trans_valid_i   read transaction request
//   trans_ready_o   request accepted (IDLE and no beat held)
//   trans_len_i     beats minus one
//   trans_offset_i  1 = halfword-misaligned start
//   fifo_valid_i    halfword available from the read FIFO
//   fifo_data_i     halfword data
//   fifo_ready_o    pop strobe to the FIFO
//   rvalid_o        beat valid (registered)
//   rready_i        bus-side ready
//   rdata_o         beat data, earlier halfword in [15:0] (registered)
//   rlast_o         last beat of the transaction (registered)
//   rerr_o          beat produced by a timeout abort (registered)
// ---------------------------------------------------------------------------
module hyper_read_packer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LEN_W          = 8
) (
    input  logic             clk0,
    input  logic             rst_i,
    input  logic             trans_valid_i,
    output logic             trans_ready_o,
    input  logic [LEN_W-1:0] trans_len_i,
    input  logic             trans_offset_i,
    input  logic             fifo_valid_i,
    input  logic [15:0]      fifo_data_i,
    output logic             fifo_ready_o,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [31:0]      rdata_o,
    output logic             rlast_o,
    output logic             rerr_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] beats_q;    // beats remaining minus one
    logic             half_q;     // 1 = next halfword completes a beat
    logic [15:0]      asm_lo_q;   // lower halfword of the beat being assembled
    logic [TW-1:0]    tmo_q;      // idle cycles since last accept / FILL entry
    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic             rlast_q;
    logic             rerr_q;

    logic out_free;
    logic hw_acc;
    logic trans_acc;
    logic last_beat;

    // Output register can take a new beat this cycle.
    assign out_free      = !rvalid_q || rready_i;
    assign trans_ready_o = (state_q == IDLE) && !rvalid_q;
    // A first halfword only goes to the assembly register, so it never waits
    // on the output; a second halfword needs the output register free.
    assign fifo_ready_o  = (state_q == FILL) && (!half_q || out_free);
    assign hw_acc        = fifo_valid_i && fifo_ready_o;
    assign trans_acc     = trans_valid_i && trans_ready_o;
    assign last_beat     = (beats_q == '0);

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign rlast_o  = rlast_q;
    assign rerr_o   = rerr_q;

    always_ff @(posedge clk0) begin
        if (rst_i) begin
            state_q  <= IDLE;
            beats_q  <= '0;
            half_q   <= 1'b0;
            asm_lo_q <= '0;
            tmo_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            // Handshake drops the beat; a reload below overrides this.
            if (rready_i) rvalid_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (trans_acc) begin
                        beats_q  <= trans_len_i;
                        half_q   <= trans_offset_i;
                        asm_lo_q <= '0;
                        tmo_q    <= '0;
                        state_q  <= FILL;
                    end
                end

                FILL: begin
                    if (hw_acc) begin
                        tmo_q <= '0;
                        if (!half_q) begin
                            asm_lo_q <= fifo_data_i;
                            half_q   <= 1'b1;
                        end else begin
                            rdata_q  <= {fifo_data_i, asm_lo_q};
                            rvalid_q <= 1'b1;
                            rlast_q  <= last_beat;
                            rerr_q   <= 1'b0;
                            half_q   <= 1'b0;
                            beats_q  <= beats_q - LEN_W'(1);
                            if (last_beat) state_q <= IDLE;
                        end
                    end else if (fifo_ready_o) begin
                        // Only true starvation counts; a held output
                        // register drops fifo_ready_o and freezes the count.
                        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                            state_q <= ABORT;
                            half_q  <= 1'b0;   // partial halfword discarded
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                end

                ABORT: begin
                    if (out_free) begin
                        rdata_q  <= '0;
                        rvalid_q <= 1'b1;
                        rlast_q  <= last_beat;
                        rerr_q   <= 1'b1;
                        beats_q  <= beats_q - LEN_W'(1);
                        if (last_beat) state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hyper_read_packer.md
# hyper_read_packer

Read-data packer in the `clk0` domain, directly downstream of the HyperBus read CDC FIFO. It pops 16-bit halfwords from the FIFO's destination port and assembles them into 32-bit beats for the bus-side read response. It handles a halfword-misaligned start and generates the last-beat flag. A data-starvation timeout terminates a transaction with error beats, so a stalled RAM cannot hang the bus.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 1024: idle `clk0` cycles with no halfword accepted before the transaction is aborted. Must be ≥2.
- `LEN_W`, default 8: width of the beat-count field.

Ports:
- `clk0`  in  1  system clock; single clock domain for the whole block.
- `rst_i`  in  1  synchronous, active-high reset.
- `trans_valid_i`  in  1  new read transaction request.
- `trans_ready_o`  out  1  high only in IDLE; the request is accepted when `trans_valid_i && trans_ready_o`.
- `trans_len_i`  in  LEN_W  number of 32-bit beats minus one.
- `trans_offset_i`  in  1  1 = start address is halfword-misaligned; the first halfword lands in `[31:16]`.
- `fifo_valid_i`  in  1  halfword available from the read CDC FIFO (`dst_valid_o`).
- `fifo_data_i`  in  16  halfword data from the FIFO.
- `fifo_ready_o`  out  1  pop strobe to the FIFO (`dst_ready_i`).
- `rvalid_o`  out  1  32-bit beat valid.
- `rready_i`  in  1  bus-side ready.
- `rdata_o`  out  32  beat data; the earlier halfword is in `[15:0]`.
- `rlast_o`  out  1  final beat of the transaction.
- `rerr_o`  out  1  beat produced by a timeout abort.

## Operation

- States: IDLE, FILL, ABORT.
- Reset:
  - state = IDLE.
  - `rvalid_o`, `rlast_o`, `rerr_o` = 0; `rdata_o` = 0.
  - Beat counter, half-select and timeout counter cleared.
- IDLE:
  - `trans_ready_o` = 1, `fifo_ready_o` = 0.
  - On accept: latch `trans_len_i`; set half-select = `trans_offset_i`; clear the assembly lower half to 0; go to FILL.
- FILL, halfword acceptance:
  - `fifo_ready_o` = 1 when half-select = 0, or when the output register is free (`!rvalid_o || rready_i`).
  - A halfword is accepted when `fifo_valid_i && fifo_ready_o`.
- FILL, half-select = 0: the accepted halfword goes to assembly `[15:0]`; half-select becomes 1.
- FILL, half-select = 1:
  - The accepted halfword plus assembly `[15:0]` load the output register.
  - `rvalid_o` = 1 and `rlast_o` = (beats remaining == 0).
  - Half-select returns to 0; beats remaining decrements.
  - If this was the last beat, go to IDLE.
- Misaligned start: the first beat has `[15:0]` = 0.
  - Halfwords consumed per transaction = 2·(len+1) − offset.
- Output register:
  - Holds its contents while `rvalid_o && !rready_i`.
  - Clears `rvalid_o` on handshake unless it is reloaded in the same cycle.
- Simultaneous events:
  - If the output handshake and the second-halfword accept fall in the same cycle, the register reloads and `rvalid_o` stays 1.
  - A transaction request arriving while the previous last beat is still held is not accepted: `trans_ready_o` requires IDLE and `!rvalid_o`.
- Timeout:
  - The counter increments each FILL cycle without an accepted halfword and clears on any accept.
  - Stalls caused by a held output register do not count.
  - On reaching `TIMEOUT_CYCLES − 1`, go to ABORT.
- ABORT:
  - `fifo_ready_o` = 0.
  - Emit the remaining beats one per handshake, with `rdata_o` = 0 and `rerr_o` = 1.
  - The final beat has `rlast_o` = 1; then go to IDLE.
  - A partially assembled halfword is discarded.
  - The block does not flush the FIFO; the controller must reset the PHY path.
- Reset mid-transaction: returns to IDLE within one cycle; any pending beat is dropped (`rvalid_o` = 0).

## Timing

- Latency: a beat is registered the cycle after its second halfword is accepted, so `rvalid_o` rises on the next `clk0` edge.
- Throughput: one halfword per cycle sustained while `rready_i` = 1.
- `trans_ready_o` and `fifo_ready_o` are combinational from state and the output register; there is no path from `fifo_valid_i` to `fifo_ready_o`.
- `rdata_o`, `rvalid_o`, `rlast_o`, `rerr_o` are registered.
- Timeout fires exactly `TIMEOUT_CYCLES` cycles after the last accept, or after entry to FILL if nothing was accepted.

## Test plan

- Aligned burst: len=3, offset=0, halfwords 0x0001..0x0008 back-to-back, `rready_i`=1 → beats 0x00020001, 0x00040003, 0x00060005, 0x00080007; `rlast_o` on the 4th only; 8 pops; `rerr_o`=0.
- Misaligned: len=1, offset=1, halfwords 0xAAAA, 0xBBBB, 0xCCCC → beats 0xAAAA0000, 0xCCCCBBBB (last); exactly 3 pops.
- Backpressure: len=3 with `rready_i` toggling 1-in-3 → no beat lost or duplicated; `fifo_ready_o`=0 while the held register blocks a second-halfword accept; order preserved.
- Timeout: `TIMEOUT_CYCLES`=16, len=2, supply 3 halfwords then stall →
  - beat 0 normal;
  - 16 cycles after the 3rd accept, enter ABORT;
  - beats 1 and 2 have data 0 and `rerr_o`=1; beat 2 has `rlast_o`=1;
  - no further pops.
- Reset mid-burst: assert `rst_i` for 1 cycle while `rvalid_o`=1 → the next cycle has `rvalid_o`=0 and `trans_ready_o`=1; a new len=0 transaction completes normally.
- Single beat back-to-back: two len=0 transactions issued consecutively with `rready_i`=1 → each has `rlast_o`=1; the second request is accepted only after the first beat's handshake.
